seven_segment_mux: RTL and testbench
====================================

# seven_segment_mux

Parametrised, time-multiplexed hex driver for a common-anode seven-segment bank of DIGITS digits. It scans one digit per slot and applies an anti-ghosting dead time at the start of each slot. New values are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new digits. It sits between user logic (switches, counters, debug registers) and the board's digit-enable and segment pins.

## Interface
- DIGITS, 4: number of digits; legal range 1..8.
- SLOT_CYCLES, 50000: clock cycles per digit slot; must be ≥ GHOST_CYCLES+1.
- GHOST_CYCLES, 16: dead-time cycles at the start of each slot with all digits off; must be ≥ 0.
- i_clk  in  1  system clock; only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_value  in  4*DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is least significant.
- i_dp  in  DIGITS  decimal-point request per digit, 1 = lit.
- i_load  in  1  single-cycle strobe; samples i_value and i_dp.
- o_Segment  out  DIGITS  digit enables, active-low; bit k = digit k.
- o_SevenSegmentDisplay  out  8  segments, active-low; bit 7 = DP, bits 6:0 = g..a.
- o_pending  out  1  high while a loaded value waits for commit.
- o_frame  out  1  one-cycle pulse when a new frame starts.

## Operation
- **Counters.**
  - Slot counter runs 0..SLOT_CYCLES-1 and wraps; width clog2(SLOT_CYCLES).
  - Digit index advances on each slot wrap: 0→1→…→DIGITS-1→0. Width max(1, clog2(DIGITS)).
- **Registers.**
  - Active register (value + dp) feeds the display.
  - Pending register (value + dp) holds loaded data until commit.
- **Load.**
  - i_load=1 writes pending and sets o_pending.
  - A second load before commit overwrites pending; last load wins.
- **Commit.** Occurs on the cycle the counters wrap to digit 0, count 0.
  - If o_pending: active ← pending, o_pending ← 0.
  - If i_load is also high that cycle: i_value/i_dp go straight to active and o_pending stays 0.
- **Display, per slot:**
  - Count < GHOST_CYCLES: o_Segment all ones; segments 8'hFF.
  - Otherwise: o_Segment = all ones except bit idx = 0; segments = decode(nibble idx) with bit 7 = ~dp[idx].
- **Decode** (active-low, DP bit 1):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E
- **Reset.**
  - Counters and index = 0; active and pending = 0; o_pending = 0; o_frame = 0.
  - o_Segment = all ones; o_SevenSegmentDisplay = 8'hFF.
  - Reset mid-load discards pending.

## Timing
- All outputs are registered: one cycle of latency from counter state to pins.
- Frame length = DIGITS*SLOT_CYCLES cycles.
- o_frame is high for exactly the cycle after commit, once per frame.
- Worst-case load-to-display latency = frame length + 1 + GHOST_CYCLES.
- DIGITS=1: index is constant 0; every slot wrap is a commit point.
- GHOST_CYCLES=0: no dead time; a digit is enabled from the first cycle of its slot.

## Configuration
- SEVEN_SEG_BLANK_EN defined: leading-zero blanking.
  - Scanning from digit DIGITS-1 downward, each digit with nibble 0 and dp 0 is blanked until the first non-zero nibble or lit DP.
  - A blanked digit's slot shows o_Segment all ones and segments 8'hFF.
  - Digit 0 is never blanked.
- Undefined: every digit is always displayed, including leading zeros.

## Structure
- Package seven_segment_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - SEG_OFF = 8'hFF;
  - the DP bit position.
- Sub-module hex_to_seg: combinational, 4-bit nibble + dp → 8-bit active-low pattern.

## Test plan
Bench parameters: DIGITS=4, SLOT_CYCLES=8, GHOST_CYCLES=2.
- **Reset.** Reset held 3 cycles, then released → o_Segment=4'b1111 and segments 8'hFF on reset cycles; digit 0 then shows C0 from cycle 3 of slot 0.
- **Scan.** i_load with value 16'h12AF, dp=0 → after commit, per frame: digit 0 8E, digit 1 88, digit 2 A4, digit 3 F9. Enables 1110, 1101, 1011, 0111, each for 6 cycles after 2 dark cycles.
- **Tear-free update.** Load 16'h1111 mid-frame, then 16'h2222 before commit → o_pending=1 until the wrap; the next frame shows only 2222, never 1111 or a mix.
- **Simultaneous load and commit.** i_load coincident with commit → new value shown in that frame; o_pending never rises.
- **DP.** dp=4'b0100 on value 16'h0000 → digit 2 segments 0x40; other digits C0.
- **Blanking** (SEVEN_SEG_BLANK_EN, value 16'h0050) → digits 3 and 2 dark; digit 1 92; digit 0 C0. Without the macro, digits 3 and 2 show C0.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment scanner: the active-low hex glyph
// table, the all-dark segment pattern and the decimal-point bit position.
package seven_segment_pkg;

  localparam int SEG_W  = 8;
  localparam int DP_BIT = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;

  // Glyphs for 0..F, entry n at HEX_TABLE[n]; DP bit is left dark (1).
  localparam logic [15:0][SEG_W-1:0] HEX_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seven_segment_mux_hex_to_seg.sv
// Combinational nibble-to-glyph decoder. Produces the active-low segment
// pattern for one hex digit with the decimal point merged into bit 7.
module hex_to_seg
  import seven_segment_pkg::*;
(
  input  logic [3:0]       i_nibble,
  input  logic             i_dp,
  output logic [SEG_W-1:0] o_seg
);

  // Look up the glyph, then overwrite the DP bit (lit = 0).
  always_comb begin
    o_seg         = HEX_TABLE[i_nibble];
    o_seg[DP_BIT] = ~i_dp;
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed hex driver for a common-anode seven-segment bank.
// One digit is scanned per slot, with a dark dead time at the start of each
// slot to suppress ghosting. Loaded values sit in a pending register and are
// only copied into the displayed register at the frame boundary, so a frame
// never mixes old and new digits.
// Optional build macro: SEVEN_SEG_BLANK_EN enables leading-zero blanking.
module seven_segment_mux
  import seven_segment_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GHOST_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_load,
  output logic [DIGITS-1:0]     o_Segment,
  output logic [SEG_W-1:0]      o_SevenSegmentDisplay,
  output logic                  o_pending,
  output logic                  o_frame
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    slot_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic                slot_wrap;
  logic                frame_wrap;

  logic [4*DIGITS-1:0] active_value;
  logic [DIGITS-1:0]   active_dp;
  logic [4*DIGITS-1:0] pending_value;
  logic [DIGITS-1:0]   pending_dp;

  logic [3:0]          cur_nibble;
  logic                cur_dp;
  logic [DIGITS-1:0]   digit_en;
  logic [SEG_W-1:0]    decoded_seg;
  logic                in_ghost;
  logic                cur_blank;

  assign slot_wrap  = (slot_cnt == CNT_LAST);
  assign frame_wrap = slot_wrap && (digit_idx == IDX_LAST);

  // Slot counter and digit index; the index steps once per slot wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_wrap) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
    end
  end

  // Double buffer: loads go to pending, commit copies into active at the
  // frame boundary; a load landing on the commit cycle bypasses pending.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      active_value  <= '0;
      active_dp     <= '0;
      pending_value <= '0;
      pending_dp    <= '0;
      o_pending     <= 1'b0;
    end else if (frame_wrap) begin
      if (i_load) begin
        active_value <= i_value;
        active_dp    <= i_dp;
      end else if (o_pending) begin
        active_value <= pending_value;
        active_dp    <= pending_dp;
      end
      o_pending <= 1'b0;
    end else if (i_load) begin
      pending_value <= i_value;
      pending_dp    <= i_dp;
      o_pending     <= 1'b1;
    end
  end

  // Frame-start pulse, high for the cycle right after the commit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_frame <= 1'b0;
    end else begin
      o_frame <= frame_wrap;
    end
  end

  // Pick the scanned digit's nibble/dp and build its active-low enable.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    digit_en   = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_nibble  = active_value[4*k +: 4];
        cur_dp      = active_dp[k];
        digit_en[k] = 1'b0;
      end
    end
  end

  generate
    if (GHOST_CYCLES > 0) begin : g_ghost
      assign in_ghost = (slot_cnt < CNT_W'(GHOST_CYCLES));
    end else begin : g_no_ghost
      assign in_ghost = 1'b0;
    end
  endgenerate

`ifdef SEVEN_SEG_BLANK_EN
  logic [DIGITS-1:0] blank_mask;
  logic              zero_run;

  // Walk down from the top digit; stay blank while nibble and dp are zero.
  // Digit 0 always shows.
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run      = zero_run && (active_value[4*k +: 4] == 4'h0) && !active_dp[k];
      blank_mask[k] = zero_run;
    end
  end

  assign cur_blank = |(blank_mask & ~digit_en);
`else
  assign cur_blank = 1'b0;
`endif

  hex_to_seg u_hex_to_seg (
    .i_nibble (cur_nibble),
    .i_dp     (cur_dp),
    .o_seg    (decoded_seg)
  );

  // Registered pin drive: dark during dead time or blanking, else the glyph.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_Segment             <= '1;
      o_SevenSegmentDisplay <= SEG_OFF;
    end else if (in_ghost || cur_blank) begin
      o_Segment             <= '1;
      o_SevenSegmentDisplay <= SEG_OFF;
    end else begin
      o_Segment             <= digit_en;
      o_SevenSegmentDisplay <= decoded_seg;
    end
  end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux with DIGITS=4, SLOT_CYCLES=8, GHOST_CYCLES=2.
// Expected frames are pushed to a scoreboard when a load is driven and popped
// at the commit point; every cycle the pins are compared with the frame that
// should be on display. Honours SEVEN_SEG_BLANK_EN when choosing expectations.
module tb_seven_segment_mux;

  localparam int FRAME = 32;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0][7:0] seg;
    logic [3:0]      dark;
  } vec_t;

  typedef struct packed {
    logic [3:0][7:0] seg;
    logic [3:0]      dark;
  } frame_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_value = '0;
  logic [3:0]  i_dp = '0;
  logic        i_load = 1'b0;
  logic [3:0]  o_Segment;
  logic [7:0]  o_SevenSegmentDisplay;
  logic        o_pending;
  logic        o_frame;

  int     pos = -1;
  int     total_checks = 0;
  int     passed_checks = 0;
  bit     exp_pending = 1'b0;
  frame_t cur;
  frame_t reset_frame;
  frame_t sb [$];
  vec_t   vecs [7];
  vec_t   v1111;
  vec_t   v2222;

  seven_segment_mux #(
    .DIGITS       (4),
    .SLOT_CYCLES  (8),
    .GHOST_CYCLES (2)
  ) dut (
    .i_clk                 (i_clk),
    .i_reset               (i_reset),
    .i_value               (i_value),
    .i_dp                  (i_dp),
    .i_load                (i_load),
    .o_Segment             (o_Segment),
    .o_SevenSegmentDisplay (o_SevenSegmentDisplay),
    .o_pending             (o_pending),
    .o_frame               (o_frame)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    total_checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s pos=%0d got=%h expected=%h", name, pos, actual, expected);
    end else begin
      passed_checks++;
    end
  endtask

  // One clock: update expected pending flag, compare all pins at negedge,
  // and swap in the committed frame after the wrap cycle.
  task automatic step_check();
    bit         ld;
    int         cnt;
    int         dig;
    logic [3:0] exp_en;
    logic [7:0] exp_seg;
    ld = i_load;
    @(posedge i_clk);
    pos++;
    if ((pos % FRAME) == FRAME - 1) exp_pending = 1'b0;
    else if (ld) exp_pending = 1'b1;
    @(negedge i_clk);
    cnt = pos % 8;
    dig = (pos / 8) % 4;
    if (cnt < 2 || cur.dark[dig]) begin
      exp_en  = 4'b1111;
      exp_seg = 8'hFF;
    end else begin
      exp_en  = ~(4'b0001 << dig);
      exp_seg = cur.seg[dig];
    end
    checkOutput("enable", {4'h0, o_Segment}, {4'h0, exp_en});
    checkOutput("segments", o_SevenSegmentDisplay, exp_seg);
    checkOutput("pending", {7'h0, o_pending}, {7'h0, exp_pending});
    checkOutput("frame", {7'h0, o_frame}, {7'h0, ((pos % FRAME) == FRAME - 1)});
    if (((pos % FRAME) == FRAME - 1) && (sb.size() > 0)) cur = sb.pop_front();
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step_check();
  endtask

  // Step until the next edge is the given frame position.
  task automatic run_to(input int target);
    while (((pos + 1) % FRAME) != target) step_check();
  endtask

  // Drive a single-cycle load and push its expected frame; last load wins.
  task automatic applyStimulus(input vec_t v);
    frame_t f;
    f.seg   = v.seg;
    f.dark  = v.dark;
    i_value = v.value;
    i_dp    = v.dp;
    i_load  = 1'b1;
    if (sb.size() > 0) sb.delete();
    sb.push_back(f);
    step_check();
    i_load = 1'b0;
  endtask

  task automatic do_reset(input int n);
    i_reset = 1'b1;
    i_load  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("rst_enable", {4'h0, o_Segment}, 8'h0F);
      checkOutput("rst_segments", o_SevenSegmentDisplay, 8'hFF);
      checkOutput("rst_pending", {7'h0, o_pending}, 8'h00);
      checkOutput("rst_frame", {7'h0, o_frame}, 8'h00);
    end
    i_reset     = 1'b0;
    pos         = -1;
    exp_pending = 1'b0;
    sb.delete();
    cur = reset_frame;
  endtask

  initial begin
    vecs[0] = '{16'h12AF, 4'b0000, {8'hF9, 8'hA4, 8'h88, 8'h8E}, 4'b0000};
    vecs[3] = '{16'h3E7D, 4'b1001, {8'h30, 8'h86, 8'hF8, 8'h21}, 4'b0000};
    vecs[4] = '{16'h8C64, 4'b0000, {8'h80, 8'hC6, 8'h82, 8'h99}, 4'b0000};
`ifdef SEVEN_SEG_BLANK_EN
    vecs[1] = '{16'h0000, 4'b0100, {8'hFF, 8'h40, 8'hC0, 8'hC0}, 4'b1000};
    vecs[2] = '{16'h0050, 4'b0000, {8'hFF, 8'hFF, 8'h92, 8'hC0}, 4'b1100};
    vecs[5] = '{16'h0009, 4'b0010, {8'hFF, 8'hFF, 8'h40, 8'h90}, 4'b1100};
    vecs[6] = '{16'h0000, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4'b1110};
`else
    vecs[1] = '{16'h0000, 4'b0100, {8'hC0, 8'h40, 8'hC0, 8'hC0}, 4'b0000};
    vecs[2] = '{16'h0050, 4'b0000, {8'hC0, 8'hC0, 8'h92, 8'hC0}, 4'b0000};
    vecs[5] = '{16'h0009, 4'b0010, {8'hC0, 8'hC0, 8'h40, 8'h90}, 4'b0000};
    vecs[6] = '{16'h0000, 4'b0000, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b0000};
`endif
    v1111 = '{16'h1111, 4'b0000, {8'hF9, 8'hF9, 8'hF9, 8'hF9}, 4'b0000};
    v2222 = '{16'h2222, 4'b0000, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 4'b0000};
    reset_frame.seg  = vecs[6].seg;
    reset_frame.dark = vecs[6].dark;

    $display("[TB] reset and idle frame");
    do_reset(3);
    run_n(FRAME);

    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++) begin
      run_to(10 + i);
      applyStimulus(vecs[i]);
      run_to(0);
      run_n(FRAME);
    end

    $display("[TB] tear-free double load");
    run_to(5);
    applyStimulus(v1111);
    run_to(20);
    applyStimulus(v2222);
    run_to(0);
    run_n(FRAME);

    $display("[TB] load coincident with commit");
    run_to(31);
    applyStimulus(vecs[3]);
    run_n(FRAME);

    $display("[TB] reset discards pending load");
    run_to(8);
    applyStimulus(vecs[0]);
    run_n(3);
    do_reset(2);
    run_n(2 * FRAME);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
